// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, rate codes, FSM states and divisor lookup.
// Holds the 100 MHz divisor table and a rounding fallback for other clocks.
package uart_pkg;
  typedef enum logic [2:0] {
    BAUD300, BAUD1200, BAUD4800, BAUD9600,
    BAUD19200, BAUD38400, BAUD57600, BAUD115200
  } baud_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int OVERSAMPLE = 16;
  localparam int FRAME_BITS = 11;
  localparam logic [14:0] DIVISOR [8] = '{
    15'd20833, 15'd5208, 15'd1302, 15'd651, 15'd326, 15'd163, 15'd109, 15'd54
  };
  localparam int BAUD_RATE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
  // The table is exact for 100 MHz x16; any other clock rounds to nearest.
  function automatic logic [14:0] calc_divisor(input int clk_hz, input int os, input logic [2:0] code);
    return (clk_hz == 100_000_000 && os == OVERSAMPLE) ? DIVISOR[code] :
      15'((clk_hz + os * BAUD_RATE[code] / 2) / (os * BAUD_RATE[code]));
  endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running divider producing one sample tick every D clocks.
// Ports: clk, reset (async, high), baud_select (rate code), clear (zero the
// divider), tick (high for the clock where the count sits at D-1).
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       clear,
  output logic       tick
);
  logic [14:0] div_tab [8];
  logic [14:0] count;
  for (genvar i = 0; i < 8; i++) begin : g_div
    assign div_tab[i] = calc_divisor(CLK_HZ, OVERSAMPLE, 3'(i));
  end
  assign tick = count == div_tab[baud_select] - 15'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= (clear || tick) ? '0 : count + 15'd1;
endmodule

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: serialises one byte per write as start, 8 data LSB-first,
// even parity, stop. Ports: clk, reset (async, high), baud_select (rate code),
// Tx_EN (gates new writes), Tx_WR (write strobe), Tx_DATA (byte), TxD (serial
// line, idle high), Tx_BUSY (high from acceptance to end of stop bit).
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);
  localparam int SW = $clog2(OVERSAMPLE);
  state_e state, nxt;
  logic [7:0] data_q;
  logic par_q, tick, accept, bit_end, txd_nxt;
  logic [2:0] rate_q, bit_idx, bit_nxt;
  logic [SW-1:0] sample;
  assign accept = Tx_WR & Tx_EN & ~Tx_BUSY;
  assign bit_end = tick & (sample == SW'(OVERSAMPLE - 1));
  // Rate is latched at acceptance so a mid-frame baud_select change is ignored.
  baud_tick_gen #(.CLK_HZ(CLK_HZ), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk(clk), .reset(reset), .baud_select(rate_q), .clear(accept), .tick(tick)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? START : IDLE;
      START:   nxt = bit_end ? DATA : START;
      DATA:    nxt = (bit_end && bit_idx == 3'd7) ? PARITY : DATA;
      PARITY:  nxt = bit_end ? STOP : PARITY;
      STOP:    nxt = bit_end ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
    bit_nxt = (state == DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;
    // Outputs are computed from the next state so TxD/Tx_BUSY can be flops.
    txd_nxt = nxt == START ? 1'b0 : nxt == DATA ? data_q[bit_nxt] : nxt == PARITY ? par_q : 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      rate_q  <= '0;
      bit_idx <= '0;
      sample  <= '0;
      TxD     <= 1'b1;
      Tx_BUSY <= 1'b0;
    end else begin
      state   <= nxt;
      bit_idx <= bit_nxt;
      TxD     <= txd_nxt;
      Tx_BUSY <= nxt != IDLE;
      if (accept) begin
        data_q <= Tx_DATA;
        par_q  <= ^Tx_DATA;
        rate_q <= baud_select;
        sample <= '0;
      end else if (tick && state != IDLE) begin
        sample <= bit_end ? '0 : sample + SW'(1);
      end
    end
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: randomized self-checking bench against a frame-level model.
module tb_uart_tx_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] baud_select = '0;
  logic Tx_EN = 1'b0, Tx_WR = 1'b0;
  logic [7:0] Tx_DATA = '0;
  logic TxD, Tx_BUSY;
  int n_cmp = 0, n_bad = 0;
  int div_of [8] = '{20833, 5208, 1302, 651, 326, 163, 109, 54};
  uart_tx_controller dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .Tx_EN(Tx_EN),
    .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .TxD(TxD), .Tx_BUSY(Tx_BUSY)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  // Called at a negedge with Tx_BUSY low; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] b, input logic [2:0] bs, input bit hold, input string tag);
    Tx_DATA = b; baud_select = bs; Tx_EN = 1'b1; Tx_WR = 1'b1;
    @(negedge clk);
    if (!hold) Tx_WR = 1'b0;
    check({tag, "_acc_txd"}, TxD, 0);
    check({tag, "_acc_busy"}, Tx_BUSY, 1);
  endtask
  // Model: frame = {stop, even parity, byte, start}; bit n owns clocks [16Dn, 16D(n+1)).
  task automatic watch_frame(input logic [7:0] b, input int d, input string tag, input bit junk);
    logic [10:0] fr;
    int bad, len, n;
    fr = {1'b1, ^b, b, 1'b0};
    len = 11 * 16 * d;
    bad = 0;
    for (int t = 0; t < len; t++) begin
      n = t / (16 * d);
      if (TxD !== fr[n] || Tx_BUSY !== 1'b1) bad++;
      if (t % (16 * d) == 8 * d) check($sformatf("%s_bit%0d", tag, n), TxD, fr[n]);
      if (junk) begin
        Tx_DATA = 8'($urandom); Tx_WR = 1'($urandom); Tx_EN = 1'($urandom); baud_select = 3'($urandom);
        if (t == len / 2) begin Tx_DATA = 8'hFF; Tx_WR = 1'b1; Tx_EN = 1'b1; end
      end
      @(negedge clk);
    end
    if (junk) Tx_WR = 1'b0;
    check({tag, "_clkerr"}, bad, 0);
    check({tag, "_end_txd"}, TxD, 1);
    check({tag, "_end_busy"}, Tx_BUSY, 0);
  endtask
  initial begin
    int bad;
    logic [7:0] b;
    repeat (5) @(negedge clk);
    check("rst_txd", TxD, 1);
    check("rst_busy", Tx_BUSY, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      Tx_DATA = 8'($urandom); baud_select = 3'($urandom); Tx_EN = 1'($urandom);
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad++;
    end
    check("idle_1000", bad, 0);
    send(8'hA5, 3'd7, 1'b0, "a5");
    watch_frame(8'hA5, div_of[7], "a5", 1'b1);
    Tx_EN = 1'b0; Tx_DATA = 8'h3C; Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad++;
      @(negedge clk);
    end
    check("gated", bad, 0);
    send(8'h00, 3'd7, 1'b1, "b2b1");
    Tx_DATA = 8'hFF; baud_select = 3'd6;
    watch_frame(8'h00, div_of[7], "b2b1", 1'b0);
    @(negedge clk);
    check("b2b2_acc_txd", TxD, 0);
    check("b2b2_acc_busy", Tx_BUSY, 1);
    watch_frame(8'hFF, div_of[6], "b2b2", 1'b0);
    Tx_WR = 1'b0;
    @(negedge clk);
    b = 8'($urandom);
    send(b, 3'd5, 1'b0, "pre_rst");
    repeat (16 * div_of[5] * 4 + 1000) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_txd", TxD, 1);
    check("async_rst_busy", Tx_BUSY, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    b = 8'($urandom);
    send(b, 3'd5, 1'b0, "post_rst");
    watch_frame(b, div_of[5], "post_rst", 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
